// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the instruction cache: line, tag/index/offset fields
// and the fill-controller state encoding.
package lc3b_types;

  localparam int C_NUM_SETS = 8;
  localparam int C_IDX_W    = $clog2(C_NUM_SETS);
  localparam int C_TAG_W    = 16 - 4 - C_IDX_W;

  typedef logic [127:0]         lc3b_line;
  typedef logic [C_TAG_W-1:0]   lc3b_c_tag;
  typedef logic [C_IDX_W-1:0]   lc3b_c_index;
  typedef logic [2:0]           lc3b_c_offset;
  typedef logic [15:0]          lc3b_word;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_control.sv
// IDLE/FILL controller for the instruction cache: decodes hit response,
// fill request and the array load strobe from the current state.
module icache_control
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_mem_read,
  input  logic          i_tag_hit,
  input  logic          i_pmem_resp,
  output logic          o_mem_resp,
  output logic          o_pmem_read,
  output logic          o_load_line,
  output icache_state_e o_state
);

  icache_state_e r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_mem_read && !i_tag_hit) r_state <= ST_FILL;
        ST_FILL: if (i_pmem_resp)              r_state <= ST_IDLE;
        default:                               r_state <= ST_IDLE;
      endcase
    end
  end

  // Hits answer in the same cycle; a reset edge abandons any fill in flight.
  assign o_mem_resp  = rst_n && (r_state == ST_IDLE) && i_mem_read && i_tag_hit;
  assign o_pmem_read = (r_state == ST_FILL);
  assign o_load_line = rst_n && (r_state == ST_FILL) && i_pmem_resp;
  assign o_state     = r_state;

endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: zero-latency hits, single-line
// fills from physical memory on a miss.
module icache_responder
  import lc3b_types::*;
#(
  parameter int NUM_SETS  = 8,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          mem_address,
  input  logic                 mem_read,
  output logic [15:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [15:0]          pmem_address,
  output logic                 pmem_read,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  logic [LINE_BITS-1:0] r_data [NUM_SETS];
  logic [TAG_W-1:0]     r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0]  r_valid;
  logic [15:0]          r_fill_addr;

  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_idx;
  lc3b_c_offset         w_word;
  logic [TAG_W-1:0]     w_cap_tag;
  logic [IDX_W-1:0]     w_cap_idx;
  logic                 w_tag_hit;
  logic                 w_mem_resp;
  logic                 w_load;
  icache_state_e        w_state;
  logic                 w_unused_addr0;

  assign w_tag          = mem_address[15:4+IDX_W];
  assign w_idx          = mem_address[3+IDX_W:4];
  assign w_word         = mem_address[3:1];
  assign w_unused_addr0 = mem_address[0];
  assign w_cap_tag      = r_fill_addr[15:4+IDX_W];
  assign w_cap_idx      = r_fill_addr[3+IDX_W:4];

  assign w_tag_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  icache_control u_control (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_read  (mem_read),
    .i_tag_hit   (w_tag_hit),
    .i_pmem_resp (pmem_resp),
    .o_mem_resp  (w_mem_resp),
    .o_pmem_read (pmem_read),
    .o_load_line (w_load),
    .o_state     (w_state)
  );

  // The fill address is latched once on the miss so a changing PC cannot disturb the fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fill_addr <= 16'h0000;
    end else if ((w_state == ST_IDLE) && mem_read && !w_tag_hit) begin
      r_fill_addr <= {mem_address[15:4], 4'b0000};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_load) begin
      r_valid[w_cap_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data[w_cap_idx] <= pmem_rdata;
      r_tag[w_cap_idx]  <= w_cap_tag;
    end
  end

  assign mem_resp     = w_mem_resp;
  assign mem_rdata    = w_mem_resp ? r_data[w_idx][16*w_word +: 16] : 16'h0000;
  assign pmem_address = r_fill_addr;

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Read-only, direct-mapped instruction cache. It is the responder for the fetch stage's PC-addressed memory reads.
- Sits between the fetch stage (word requests: address, read strobe, data, response) and physical memory (128-bit line reads).
- Returns the 16-bit instruction word at the requested PC. Hits are serviced in the same cycle; misses are serviced by a single line fill.

Parameters:
- NUM_SETS, 8, number of cache lines; power of two, minimum 2. Index width IDX_W = log2(NUM_SETS).
- LINE_BITS, 128, line width in bits; fixed at 8 words per line, offset = address[3:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- mem_address  input  16  fetch byte address (PC); bit 0 ignored.
- mem_read  input  1  fetch request strobe; held high until mem_resp.
- mem_rdata  output  16  instruction word; valid only while mem_resp=1.
- mem_resp  output  1  fetch response; high for exactly the cycle(s) data is valid.
- pmem_address  output  16  line-aligned fill address; bits [3:0] = 0.
- pmem_read  output  1  line fill request; held high until pmem_resp.
- pmem_rdata  input  128  fill line data; word k = bits [16k+15:16k].
- pmem_resp  input  1  fill complete; single-cycle pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Address split: tag = mem_address[15:4+IDX_W], index = mem_address[3+IDX_W:4], word = mem_address[3:1].
- Storage: per set, one valid bit, one tag, one 128-bit line. Arrays are registered, written only by fills.
- Reset (rst_n=0 at edge):
  - all valid bits cleared; FSM to IDLE; captured fill address cleared to 0x0000.
  - Outputs during and after reset: mem_resp=0, pmem_read=0, pmem_address=0x0000, mem_rdata=0x0000.
  - Tag and data arrays are not cleared.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = mem_read & valid[index] & (tag_array[index]==tag).
  - On hit: mem_resp=1 and mem_rdata=line[index] word selected by word, combinationally in the same cycle. Zero-cycle hit latency; no state change.
  - On mem_read & !hit: capture {mem_address[15:4],4'b0} into the fill address register; next state FILL; mem_resp=0.
  - With mem_read=0: mem_resp=0, mem_rdata=0x0000.
- FILL:
  - pmem_read=1; pmem_address = captured register, stable for the whole fill; mem_resp=0.
  - On pmem_resp=1: write the line into data[cap_index]; tag[cap_index] = cap_tag; valid[cap_index] = 1; next state IDLE.
  - The first hit can occur in the cycle after the fill. Miss latency = fill cycles + 1.
- Boundary conditions:
  - pmem_resp while in IDLE: ignored; no array write.
  - mem_read dropped or mem_address changed mid-FILL: the fill completes to the captured address; the new request is evaluated in IDLE afterwards.
  - rst_n=0 mid-FILL: fill abandoned; pmem_read drops in the cycle after the reset edge. A late pmem_resp is ignored per the IDLE rule.
  - Conflict miss: the fill overwrites the resident line unconditionally. There is no write-back (read-only cache).
  - Address 0xFFFE: tag all ones, index NUM_SETS-1, word 7. No wrap special case.

Decomposition:
- Shared package (lc3b_types) additions:
  - lc3b_line (128-bit)
  - lc3b_c_tag
  - lc3b_c_index
  - lc3b_c_offset (3-bit word select)
- Sub-module icache_control holds the IDLE/FILL FSM and decodes the hit, pmem_read, mem_resp and array-load signals.
- The top level holds the arrays, comparator, fill-address register and word mux.

Test Plan:
- Reset then read 0x0000:
  - FILL requested with pmem_address=0x0000.
  - Return line with word0=0x1234 after 3 cycles; mem_resp=1 with mem_rdata=0x1234 in the cycle after pmem_resp.
- Sequential hits:
  - After fill of 0x0000, read 0x0002..0x000E on consecutive cycles.
  - Each gets same-cycle mem_resp with line words 1..7; pmem_read stays 0.
- Conflict (NUM_SETS=8):
  - Read 0x0000, then 0x0080 (same index, tag differs) → second FILL at 0x0080.
  - Re-read 0x0000 → miss again with pmem_address=0x0000.
- Address change mid-fill:
  - Read 0x0040 miss; after 1 cycle switch mem_address to 0x0100.
  - pmem_address stays 0x0040; after the fill, a new FILL starts at 0x0100.
- Reset mid-fill:
  - Assert rst_n=0 during FILL; pmem_read=0 next cycle.
  - A stray pmem_resp is ignored; a subsequent read of the same address misses.
- Top address: read 0xFFFE, fill line with word7=0xBEEF → mem_rdata=0xBEEF; the set-7 valid bit is set.
